trig_readout_arbiter: RTL

//  Shares one waveform capture engine among N_CH trigger channels, each fed by
//  an extended FIR discriminator pulse. Rising edges are latched as pending

---
 rtl/trig_readout_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/trig_readout_arbiter.sv
// Round-robin arbiter sharing one waveform capture engine among N_CH trigger channels.
// Each grant runs start -> wait for done or timeout -> deadtime before the next grant.
//
// state  | meaning
// S_IDLE | no capture in flight; grants the next pending channel
// S_WAIT | capture started, waiting for cap_done or timeout
// S_DEAD | enforced idle gap after a capture
module trig_readout_arbiter #(
    parameter int N_CH     = 4,
    parameter int DEADTIME = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [N_CH-1:0]         trig_in,
    input  logic                    cap_done,
    output logic                    cap_start,
    output logic [$clog2(N_CH)-1:0] cap_ch,
    output logic                    busy,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH-1:0]         drop,
    output logic                    timeout_err
);

    localparam int CHW = $clog2(N_CH);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] DT_LAST = (DEADTIME > 0) ? 32'(DEADTIME - 1) : 32'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_CH-1:0]   trig_q;
    logic [N_CH-1:0]   edge_det;
    logic [N_CH-1:0]   grant_vec;
    logic [N_CH-1:0]   pending_nxt;
    logic [N_CH-1:0]   drop_nxt;
    logic [CHW-1:0]    last_grant;
    logic [CHW-1:0]    last_grant_nxt;
    logic [CHW-1:0]    sel;
    logic [CHW-1:0]    cap_ch_nxt;
    logic [31:0]       counter;
    logic [31:0]       counter_nxt;
    logic              cap_start_nxt;
    logic              timeout_nxt;

    // First requesting channel after 'last', wrapping around.
    function automatic logic [CHW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                               input logic [CHW-1:0]  last);
        logic [CHW-1:0] pick;
        logic [CHW-1:0] cand;
        logic           found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CHW'((int'(last) + i) % N_CH);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign edge_det    = trig_in & ~trig_q;
    assign pending_nxt = enable ? ((pending & ~grant_vec) | edge_det) : '0;
    assign drop_nxt    = edge_det & pending & ~grant_vec & {N_CH{enable}};
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (|pending) state_nxt = S_WAIT;
            S_WAIT: if (cap_done || counter == TO_LAST)
                        state_nxt = (DEADTIME > 0) ? S_DEAD : S_IDLE;
            S_DEAD: if (counter == DT_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sel            = rr_pick(pending, last_grant);
        grant_vec      = '0;
        cap_start_nxt  = 1'b0;
        timeout_nxt    = 1'b0;
        counter_nxt    = counter;
        cap_ch_nxt     = cap_ch;
        last_grant_nxt = last_grant;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    grant_vec[sel] = 1'b1;
                    cap_start_nxt  = 1'b1;
                    cap_ch_nxt     = sel;
                    last_grant_nxt = sel;
                    counter_nxt    = '0;
                end
            end
            S_WAIT: begin
                counter_nxt = counter + 32'd1;
                if (cap_done) begin
                    counter_nxt = '0;
                end else if (counter == TO_LAST) begin
                    timeout_nxt = 1'b1;
                    counter_nxt = '0;
                end
            end
            S_DEAD: counter_nxt = counter + 32'd1;
            default: begin
                cap_ch_nxt  = '0;
                counter_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trig_q      <= '0;
            pending     <= '0;
            drop        <= '0;
            last_grant  <= CHW'(N_CH - 1);
            counter     <= '0;
            cap_start   <= 1'b0;
            cap_ch      <= '0;
            timeout_err <= 1'b0;
        end else begin
            trig_q      <= trig_in;
            pending     <= pending_nxt;
            drop        <= drop_nxt;
            last_grant  <= last_grant_nxt;
            counter     <= counter_nxt;
            cap_start   <= cap_start_nxt;
            cap_ch      <= cap_ch_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule
